fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction fetch stage of the RISC-V core; owns the PC register and its next-PC logic.
//  Issues in-order requests to instruction memory and buffers responses in a small queue.
//  Hands {pc, instr} pairs to decode over a valid/ready handshake; applies branch/jump redirects.
// PARAMETERS
//  PC_W      8        PC / instruction-address width (byte address, modulo 2^PC_W)
//  INSTR_W   32       instruction width
//  RESET_PC  8'h00    PC after reset
//  Q_DEPTH   2        fetch-queue entries; also max requests in flight (power of 2, >=2)
// PORTS
//  clk             in   1        rising-edge clock
//  reset           in   1        asynchronous, active-low reset
//  imem_req_valid  out  1        request valid
//  imem_req_ready  in   1        memory accepts request
//  imem_req_addr   out  PC_W     request byte address (low 2 bits always 0)
//  imem_rsp_valid  in   1        response valid; in order; >=1 cycle after acceptance
//  imem_rsp_data   in   INSTR_W  response instruction
//  redirect_valid  in   1        branch/jump taken; 1-cycle pulse from execute
//  redirect_pc     in   PC_W     redirect target; bits [1:0] ignored (forced 0)
//  out_valid       out  1        {out_pc,out_instr} valid to decode
//  out_ready       in   1        decode accepts
//  out_pc          out  PC_W     PC of out_instr
//  out_instr       out  INSTR_W  instruction to decode
// BEHAVIOUR
//  Reset (reset==0, async): pc=RESET_PC, state=BOOT, queue empty, inflight=0, drop=0;
//   imem_req_valid=0, out_valid=0, imem_req_addr=RESET_PC, out_pc=0, out_instr=0.
//  States: BOOT -> FETCH unconditionally on first clock after reset deasserts (no request in BOOT).
//   FETCH -> FLUSH on redirect_valid with (inflight - accepting rsp) > 0; else stays FETCH.
//   FLUSH -> FETCH in the cycle drop reaches 0; redirect in FLUSH: reload pc, stay FLUSH.
//  Issue: imem_req_valid = (state==FETCH) & !redirect_valid & (inflight + q_count < Q_DEPTH).
//   imem_req_addr = pc. On req accept: pc <= pc + 4 (wraps 8'hFC -> 8'h00), inflight++.
//   Addr/valid held stable while valid & !ready.
//  Response: rsp_valid with drop==0 -> push {pc_of_req, data}; credit rule guarantees no overflow.
//   rsp_valid with drop>0 -> discard, drop--. Every response: inflight--.
//   Request PC tracked by an in-flight PC FIFO (or pc minus 4*outstanding).
//  Output: out_valid = queue non-empty (or same-cycle bypass of rsp when empty, first-word-fall-
//   through); pop on out_valid & out_ready; push and pop in the same cycle allowed when full.
//  Redirect (highest priority): pc <= {redirect_pc[PC_W-1:2],2'b00}; queue flushed same edge;
//   drop <= inflight after that cycle's accepts/responses; no request issued in the redirect cycle;
//   out_valid=0 in the cycle after redirect. Redirect with a same-cycle out handshake: pop still
//   counts (decode already took it).
//  Latency: redirect -> first req 1 cycle (if nothing in flight); rsp -> out_valid 0 cycles when queue empty.
//  Invariants: inflight + q_count <= Q_DEPTH; rsp_valid with inflight==0 is illegal (assert).
// CONFIGURATION
//  FETCH_PERF_CNT_EN defined: adds outputs perf_stall_cnt[15:0] (cycles with out_valid==0 in FETCH)
//   and perf_flush_cnt[15:0] (redirects); both saturating, reset to 0.
//  Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  fetch_pkg: PC_W, INSTR_W, RESET_PC defaults, fetch_state_e {BOOT,FETCH,FLUSH}, PC_STEP=4.
//  Sub-module fetch_queue (Q_DEPTH x {PC_W+INSTR_W}, sync push/pop, flush, count, full/empty);
//   top holds pc, FSM, inflight/drop counters, optional perf counters.
// TESTING
//  Reset release, ready=1, 1-cycle mem -> req addrs 00,04,08...; out_pc 00 first, instr matches mem.
//  out_ready=0 for 10 cycles -> at most 2 reqs issued, queue full, no req_valid until pop.
//  pc=8'hF8 free-running -> addrs F8,FC,00,04; no glitch on wrap.
//  Redirect to 8'h41 with 2 in flight -> next req addr 40 after 2 rsps dropped; out_pc 40 first.
//  Redirect in same cycle as rsp and out handshake -> popped entry consumed, rsp dropped, no stale out.
//  reset low mid-FLUSH -> all outputs at reset values immediately; with FETCH_PERF_CNT_EN counters=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
//  - Default widths and reset PC for fetch_unit.
//  - fetch_state_e: BOOT (idle after reset), FETCH (issuing), FLUSH (draining wrong-path responses).
//  - PC_STEP: byte increment between sequential instructions.
package fetch_pkg;

  localparam int PC_W_DEFAULT    = 8;
  localparam int INSTR_W_DEFAULT = 32;
  localparam logic [7:0] RESET_PC_DEFAULT = 8'h00;
  localparam int PC_STEP = 4;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    FLUSH = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_queue.sv
// Small FIFO holding fetched {pc, instr} entries waiting for decode.
// Ports:
//  clk, reset     clock, asynchronous active-low reset
//  flush          drop every entry (push/pop in the same cycle are ignored)
//  push/push_data write one entry
//  pop            remove the head entry (ignored when empty)
//  head_data      current head entry (undefined content when empty)
//  count          number of stored entries
//  full/empty     occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int W     = 40
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    push,
  input  logic [W-1:0]            push_data,
  input  logic                    pop,
  output logic [W-1:0]            head_data,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign empty     = (cnt == '0);
  assign full      = (cnt == (AW+1)'(DEPTH));
  assign count     = cnt;
  assign head_data = mem[rptr];

  // A push into a full queue is only legal when the head leaves in the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage carries data only; it needs no reset.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wptr] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues in-order requests to instruction
// memory, buffers responses and hands {pc, instr} pairs to decode.
// Optional build macro: FETCH_PERF_CNT_EN adds perf_stall_cnt / perf_flush_cnt.
// Ports:
//  clk, reset                  clock, asynchronous active-low reset
//  imem_req_valid/ready/addr   request channel (addr = current pc, word aligned)
//  imem_rsp_valid/data         in-order response channel
//  redirect_valid/redirect_pc  taken branch/jump from execute (1-cycle pulse)
//  out_valid/ready/pc/instr    handshake towards decode (first-word-fall-through)
//  perf_stall_cnt              (FETCH_PERF_CNT_EN) cycles in FETCH with no output valid
//  perf_flush_cnt              (FETCH_PERF_CNT_EN) redirects seen
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              PC_W     = PC_W_DEFAULT,
  parameter int              INSTR_W  = INSTR_W_DEFAULT,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEFAULT),
  parameter int              Q_DEPTH  = 2
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [PC_W-1:0]    imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]        perf_stall_cnt,
  output logic [15:0]        perf_flush_cnt
`endif
);

  localparam int CW = $clog2(Q_DEPTH) + 1;
  localparam int EW = PC_W + INSTR_W;

  fetch_state_e      state;
  fetch_state_e      state_nxt;
  logic [PC_W-1:0]   pc;
  logic [CW-1:0]     inflight;
  logic [CW-1:0]     inflight_nxt;
  logic [CW-1:0]     drop;
  logic [CW-1:0]     drop_nxt;
  logic [CW-1:0]     q_count;
  logic              q_full;
  logic              q_empty;
  logic              q_push;
  logic              q_pop;
  logic [EW-1:0]     q_head;
  logic              credit_ok;
  logic              req_fire;
  logic              rsp_keep;
  logic              rsp_drop;
  logic              bypass;
  logic [PC_W-1:0]   rsp_pc;
  logic [1:0]        unused_redirect_lsb;

  assign unused_redirect_lsb = redirect_pc[1:0];

  // Every outstanding request must have a queue slot waiting for it.
  assign credit_ok = ({1'b0, inflight} + {1'b0, q_count}) < (CW+1)'(Q_DEPTH);
  assign req_fire  = imem_req_valid & imem_req_ready;
  assign imem_req_addr = pc;

  // Requests since the last redirect are consecutive, so the oldest outstanding
  // one (the one being answered) sits inflight words behind pc.
  assign rsp_pc   = pc - (PC_W'(inflight) << 2);
  assign rsp_keep = imem_rsp_valid & (drop == '0) & (inflight != '0);
  assign rsp_drop = imem_rsp_valid & (drop != '0);

  assign inflight_nxt = inflight + CW'(req_fire) - CW'(imem_rsp_valid);

  // Redirect: whatever is still outstanding after this cycle is wrong-path.
  always_comb begin
    drop_nxt = drop;
    if (redirect_valid) drop_nxt = inflight_nxt;
    else if (rsp_drop)  drop_nxt = drop - 1'b1;
  end

  always_comb begin
    state_nxt      = state;
    imem_req_valid = 1'b0;
    unique case (state)
      BOOT:  state_nxt = FETCH;
      FETCH: begin
        imem_req_valid = ~redirect_valid & credit_ok;
        if (redirect_valid && inflight_nxt != '0) state_nxt = FLUSH;
      end
      FLUSH: begin
        if (!redirect_valid && drop_nxt == '0) state_nxt = FETCH;
      end
      default: state_nxt = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= BOOT;
      pc       <= RESET_PC;
      inflight <= '0;
      drop     <= '0;
    end else begin
      state    <= state_nxt;
      inflight <= inflight_nxt;
      drop     <= drop_nxt;
      if (redirect_valid)  pc <= {redirect_pc[PC_W-1:2], 2'b00};
      else if (req_fire)   pc <= pc + PC_W'(PC_STEP);
    end
  end

  // Output: queue head, or the arriving response directly when the queue is empty.
  assign bypass    = q_empty & rsp_keep;
  assign out_valid = ~q_empty | bypass;
  assign q_pop     = out_ready;
  // A redirect flushes the queue, so a same-cycle response is wrong-path and lost.
  assign q_push    = rsp_keep & ~redirect_valid & ~(bypass & out_ready);

  always_comb begin
    out_pc    = '0;
    out_instr = '0;
    if (!q_empty) begin
      {out_pc, out_instr} = q_head;
    end else if (bypass) begin
      out_pc    = rsp_pc;
      out_instr = imem_rsp_data;
    end
  end

  fetch_queue #(
    .DEPTH (Q_DEPTH),
    .W     (EW)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (q_push),
    .push_data ({rsp_pc, imem_rsp_data}),
    .pop       (q_pop),
    .head_data (q_head),
    .count     (q_count),
    .full      (q_full),
    .empty     (q_empty)
  );

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (state == FETCH && !out_valid && perf_stall_cnt != 16'hFFFF)
        perf_stall_cnt <= perf_stall_cnt + 1'b1;
      if (redirect_valid && perf_flush_cnt != 16'hFFFF)
        perf_flush_cnt <= perf_flush_cnt + 1'b1;
    end
  end
`endif

  a_no_orphan_rsp: assert property (@(posedge clk) disable iff (!reset)
    !(imem_rsp_valid && inflight == '0));
  a_credit: assert property (@(posedge clk) disable iff (!reset)
    ({1'b0, inflight} + {1'b0, q_count}) <= (CW+1)'(Q_DEPTH));
  a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
    !(q_push && q_full && !(q_pop && !q_empty)));

endmodule

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [7:0]  imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_pc;
  logic [31:0] out_instr;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] perf_stall_cnt;
  logic [15:0] perf_flush_cnt;
`endif

  fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;
  int budget = 0;
  bit rsp_stall = 1'b0;
  logic [7:0] pend_addr[$];
  logic [7:0] exp_req[$];
  logic [7:0] exp_out[$];

  function automatic logic [31:0] mem_word(input logic [7:0] a);
    return 32'hC0DE_0000 | {24'h0, a};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Memory model: accepts while budget lasts, answers in order one cycle later
  // unless rsp_stall holds responses back.
  logic       mem_acc;
  logic       mem_rfire;
  logic [7:0] mem_addr;
  initial begin
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      mem_acc   = imem_req_valid && imem_req_ready;
      mem_addr  = imem_req_addr;
      mem_rfire = imem_rsp_valid;
      @(posedge clk);
      #1;
      if (!reset) begin
        pend_addr.delete();
      end else begin
        if (mem_rfire && pend_addr.size() > 0) void'(pend_addr.pop_front());
        if (mem_acc) begin
          pend_addr.push_back(mem_addr);
          budget--;
        end
      end
      imem_req_ready = (budget > 0);
      if (pend_addr.size() > 0 && !rsp_stall) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(pend_addr[0]);
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
      end
    end
  end

  // Monitor: every accepted request and every decode handshake is scored.
  logic [7:0] mon_e;
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        if (imem_req_valid && imem_req_ready) begin
          if (exp_req.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL req_unexpected: got addr %0h expected no request", imem_req_addr);
          end else begin
            check("req_addr", imem_req_addr, exp_req.pop_front());
          end
        end
        if (out_valid && out_ready) begin
          if (exp_out.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL out_unexpected: got pc %0h expected no output", out_pc);
          end else begin
            mon_e = exp_out.pop_front();
            check("out_pc", out_pc, mon_e);
            check("out_instr", out_instr, mem_word(mon_e));
          end
        end
      end
    end
  end

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_req.size() != 0 || exp_out.size() != 0 || pend_addr.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_req.size() != 0 || exp_out.size() != 0 || pend_addr.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d reqs %0d outs pending expected 0", name, exp_req.size(), exp_out.size());
      exp_req.delete();
      exp_out.delete();
    end
    tick();
  endtask

  task automatic wait_pend(input string name, input int n);
    int k;
    k = 0;
    while (pend_addr.size() != n && k < 50) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (pend_addr.size() != n) begin
      errors++;
      $display("FAIL %s_inflight: got %0d expected %0d", name, pend_addr.size(), n);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    reset          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b0;

    // Reset values
    repeat (2) tick();
    check("rst_req_valid", imem_req_valid, 0);
    check("rst_req_addr", imem_req_addr, 8'h00);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_pc", out_pc, 8'h00);
    check("rst_out_instr", out_instr, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    check("rst_perf_stall", perf_stall_cnt, 0);
    check("rst_perf_flush", perf_flush_cnt, 0);
`endif
    tick();
    reset = 1'b1;
    @(negedge clk);
    check("boot_no_req", imem_req_valid, 0);
    @(negedge clk);
    check("fetch_req_valid", imem_req_valid, 1);
    check("fetch_req_addr", imem_req_addr, 8'h00);

    // Sequential fetch
    tick();
    out_ready = 1'b1;
    foreach (exp_req[i]) ;
    for (int i = 0; i < 4; i++) begin
      exp_req.push_back(8'(i * 4));
      exp_out.push_back(8'(i * 4));
    end
    budget = 4;
    drain("seq");
    repeat (2) begin
      @(negedge clk);
      check("hold_valid", imem_req_valid, 1);
      check("hold_addr", imem_req_addr, 8'h10);
    end

    // Decode stall: queue fills, requests stop
    tick();
    out_ready = 1'b0;
    budget = 10;
    exp_req.push_back(8'h10); exp_req.push_back(8'h14);
    exp_out.push_back(8'h10); exp_out.push_back(8'h14);
    repeat (10) tick();
    budget = 0;
    tick();
    @(negedge clk);
    check("full_no_req", imem_req_valid, 0);
    check("full_out_valid", out_valid, 1);
    check("full_head_pc", out_pc, 8'h10);
    tick();
    out_ready = 1'b1;
    drain("stall");

    // Redirect with nothing in flight, then wrap-around
    redirect_valid = 1'b1;
    redirect_pc    = 8'hF8;
    budget = 4;
    exp_req.push_back(8'hF8); exp_req.push_back(8'hFC);
    exp_req.push_back(8'h00); exp_req.push_back(8'h04);
    exp_out.push_back(8'hF8); exp_out.push_back(8'hFC);
    exp_out.push_back(8'h00); exp_out.push_back(8'h04);
    @(negedge clk);
    check("redir_no_req", imem_req_valid, 0);
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("redir_lat_valid", imem_req_valid, 1);
    check("redir_lat_addr", imem_req_addr, 8'hF8);
    check("redir_out_idle", out_valid, 0);
    drain("wrap");

    // Redirect with two requests in flight: both responses dropped
    budget = 2;
    rsp_stall = 1'b1;
    exp_req.push_back(8'h08); exp_req.push_back(8'h0C);
    wait_pend("flush", 2);
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 8'h41;
    budget = 2;
    exp_req.push_back(8'h40); exp_req.push_back(8'h44);
    exp_out.push_back(8'h40); exp_out.push_back(8'h44);
    @(negedge clk);
    check("flush_redir_no_req", imem_req_valid, 0);
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("flush_out_idle", out_valid, 0);
    check("flush_hold", imem_req_valid, 0);
    tick();
    @(negedge clk);
    check("flush_hold2", imem_req_valid, 0);
    tick();
    rsp_stall = 1'b0;
    drain("flush");

    // Redirect together with a response and a decode handshake
    out_ready = 1'b0;
    budget = 2;
    rsp_stall = 1'b1;
    exp_req.push_back(8'h48); exp_req.push_back(8'h4C); exp_req.push_back(8'h80);
    exp_out.push_back(8'h48); exp_out.push_back(8'h80);
    wait_pend("race", 2);
    tick();
    rsp_stall = 1'b0;
    tick();
    tick();
    out_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 8'h80;
    budget = 1;
    @(negedge clk);
    check("race_rsp", imem_rsp_valid, 1);
    check("race_head", out_pc, 8'h48);
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("race_out_idle", out_valid, 0);
    check("race_req_valid", imem_req_valid, 1);
    check("race_req_addr", imem_req_addr, 8'h80);
    drain("race");

    // Reset in the middle of a flush
    budget = 2;
    rsp_stall = 1'b1;
    exp_req.push_back(8'h84); exp_req.push_back(8'h88);
    wait_pend("rstflush", 2);
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 8'hC0;
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("rstflush_no_req", imem_req_valid, 0);
    tick();
    reset = 1'b0;
    #1;
    check("rst2_req_valid", imem_req_valid, 0);
    check("rst2_req_addr", imem_req_addr, 8'h00);
    check("rst2_out_valid", out_valid, 0);
    check("rst2_out_pc", out_pc, 8'h00);
    check("rst2_out_instr", out_instr, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    check("rst2_perf_stall", perf_stall_cnt, 0);
    check("rst2_perf_flush", perf_flush_cnt, 0);
`endif
    tick();
    tick();
    rsp_stall = 1'b0;
    reset = 1'b1;
    budget = 1;
    exp_req.push_back(8'h00);
    exp_out.push_back(8'h00);
    drain("post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
